// File: rtl/resp_chk_pkg.sv
// Shared definitions for the response checker: FSM states and MISR constants.
package resp_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
    localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

    // One MISR step: shift left, fold in the polynomial on carry-out, xor the new input.
    function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] din);
        return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ din;
    endfunction

endpackage

// File: rtl/resp_delay_line.sv
// Fixed-latency shift register carrying {valid, data, mask}; only valid bits are reset.
module resp_delay_line #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_mask,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_mask
);

    if (LATENCY == 0) begin : g_bypass
        logic w_unused;
        assign w_unused = i_clk ^ i_rst_n;
        assign o_valid  = i_valid;
        assign o_data   = i_data;
        assign o_mask   = i_mask;
    end else begin : g_pipe
        logic [LATENCY-1:0] r_valid;
        logic [WIDTH-1:0]   r_data [LATENCY];
        logic [WIDTH-1:0]   r_mask [LATENCY];

        // Valid bits shift toward the output and clear on reset so nothing stale emerges.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_valid <= '0;
            end else begin
                r_valid <= LATENCY'({r_valid, i_valid});
            end
        end

        // Payload shifts unconditionally; it is only looked at when its valid bit is set.
        always_ff @(posedge i_clk) begin
            r_data[0] <= i_data;
            r_mask[0] <= i_mask;
            for (int i = 1; i < LATENCY; i++) begin
                r_data[i] <= r_data[i-1];
                r_mask[i] <= r_mask[i-1];
            end
        end

        assign o_valid = r_valid[LATENCY-1];
        assign o_data  = r_data[LATENCY-1];
        assign o_mask  = r_mask[LATENCY-1];
    end

endmodule

// File: rtl/response_checker.sv
// Response checker: aligns expected vectors to DUT output through a delay line,
// compares under a mask and reports error count, first failing index and pass/done.
// Optional MISR signature enabled by defining RESP_MISR_EN.
module response_checker
    import resp_chk_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] vec_total,
    input  logic             stim_valid,
    input  logic [WIDTH-1:0] exp_data,
    input  logic [WIDTH-1:0] exp_mask,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             first_fail_valid,
    output logic [31:0]      signature
);

    chk_state_t       r_state;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_checked;
    logic [CNT_W-1:0] r_err;
    logic [CNT_W-1:0] r_ffi;
    logic             r_ffv;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_accept;
    logic             w_dl_valid;
    logic [WIDTH-1:0] w_dl_data;
    logic [WIDTH-1:0] w_dl_mask;
    logic             w_cmp;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_err_next;
    logic [CNT_W-1:0] w_checked_inc;
    logic             w_last;

    // Stimuli beyond vec_total, or outside a run, never enter the delay line.
    assign w_accept = (r_state == RUN) && stim_valid && (r_issued != r_total);

    resp_delay_line #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_delay (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_valid (w_accept),
        .i_data  (exp_data),
        .i_mask  (exp_mask),
        .o_valid (w_dl_valid),
        .o_data  (w_dl_data),
        .o_mask  (w_dl_mask)
    );

    assign w_cmp         = (r_state == RUN) && w_dl_valid;
    assign w_mismatch    = |((dut_out ^ w_dl_data) & w_dl_mask);
    assign w_err_next    = (w_mismatch && (r_err != '1)) ? r_err + CNT_W'(1) : r_err;
    assign w_checked_inc = r_checked + CNT_W'(1);
    assign w_last        = w_cmp && (w_checked_inc == r_total);

    // Run-control FSM with registered status outputs and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_total   <= '0;
            r_issued  <= '0;
            r_checked <= '0;
            r_err     <= '0;
            r_ffi     <= '0;
            r_ffv     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_total   <= vec_total;
                        r_issued  <= '0;
                        r_checked <= '0;
                        r_err     <= '0;
                        r_ffi     <= '0;
                        r_ffv     <= 1'b0;
                        // An empty run has nothing to compare and finishes clean at once.
                        if (vec_total == '0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_issued <= r_issued + CNT_W'(1);
                    end
                    if (w_cmp) begin
                        r_checked <= w_checked_inc;
                        r_err     <= w_err_next;
                        if (w_mismatch && !r_ffv) begin
                            r_ffi <= r_checked;
                            r_ffv <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef RESP_MISR_EN
    logic [31:0] r_sig;

    // Signature: seeded on start, folds the masked DUT output of every compared entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sig <= '0;
        end else if ((r_state != RUN) && start) begin
            r_sig <= MISR_SEED;
        end else if (w_cmp) begin
            r_sig <= misr_step(r_sig, 32'(dut_out & w_dl_mask));
        end
    end

    assign signature = r_sig;
`else
    assign signature = 32'h0;
`endif

    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail_idx   = r_ffi;
    assign first_fail_valid = r_ffv;

endmodule

// File: tb/tb_response_checker.sv
// Randomized self-checking bench for response_checker against a queue-based model.
module tb_response_checker;

    localparam int W   = 8;
    localparam int CW  = 16;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] vec_total = '0;
    logic          stim_valid = 1'b0;
    logic [W-1:0]  exp_data = '0;
    logic [W-1:0]  exp_mask = '0;
    logic [W-1:0]  dut_out = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] err_count;
    logic [CW-1:0] first_fail_idx;
    logic          first_fail_valid;
    logic [31:0]   signature;

    response_checker #(
        .WIDTH   (W),
        .CNT_W   (CW),
        .LATENCY (LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .vec_total        (vec_total),
        .stim_valid       (stim_valid),
        .exp_data         (exp_data),
        .exp_mask         (exp_mask),
        .dut_out          (dut_out),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_idx   (first_fail_idx),
        .first_fail_valid (first_fail_valid),
        .signature        (signature)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: a run is a list of expected entries, each due LAT cycles after acceptance.
    typedef struct {
        int           due;
        logic [W-1:0] e;
        logic [W-1:0] m;
    } ent_t;

    ent_t        q[$];
    bit          m_run, m_done, m_pass, m_ffv;
    int          m_err, m_ffi, m_total, m_issued, m_checked;
    logic [31:0] m_sig;
    int          cyc = 0;
    bit          bad_idx[64];
    int          bad_bit = 0;

    task automatic model_clear();
        q.delete();
        m_run = 0; m_done = 0; m_pass = 0; m_ffv = 0;
        m_err = 0; m_ffi = 0; m_total = 0; m_issued = 0; m_checked = 0;
        m_sig = 32'h0;
    endtask

    // Choose dut_out: the correct response (optionally corrupted) when an entry is due.
    task automatic prepare_dut();
        bit           have;
        logic [W-1:0] tgt;
        have = 0;
        tgt  = '0;
        if (LAT == 0 && m_run && stim_valid && m_issued < m_total) begin
            have = 1; tgt = exp_data;
        end else if (m_run && q.size() > 0 && q[0].due == cyc) begin
            have = 1; tgt = q[0].e;
        end
        if (have)
            dut_out = bad_idx[m_checked % 64] ? (tgt ^ W'(1 << bad_bit)) : tgt;
        else
            dut_out = W'($urandom);
    endtask

    task automatic model_step();
        bit   was_run;
        ent_t en;
        was_run = m_run;
        if (was_run && stim_valid && m_issued < m_total) begin
            q.push_back('{cyc + LAT, exp_data, exp_mask});
            m_issued++;
        end
        if (was_run && q.size() > 0 && q[0].due == cyc) begin
            en = q.pop_front();
            if (((dut_out ^ en.e) & en.m) != 0) begin
                if (!m_ffv) begin
                    m_ffv = 1;
                    m_ffi = m_checked;
                end
                if (m_err < (1 << CW) - 1) m_err++;
            end
`ifdef RESP_MISR_EN
            m_sig = {m_sig[30:0], 1'b0} ^ (m_sig[31] ? 32'h04C11DB7 : 32'h0)
                    ^ 32'(dut_out & en.m);
`endif
            m_checked++;
            if (m_checked == m_total) begin
                m_run = 0; m_done = 1; m_pass = (m_err == 0);
            end
        end
        if (!was_run && start) begin
            model_clear();
            m_total = int'(vec_total);
`ifdef RESP_MISR_EN
            m_sig = 32'hFFFFFFFF;
`endif
            if (m_total == 0) begin
                m_done = 1; m_pass = 1;
            end else begin
                m_run = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_done));
        chk("pass", 32'(pass), 32'(m_pass));
        chk("err_count", 32'(err_count), 32'(m_err));
        chk("first_fail_idx", 32'(first_fail_idx), 32'(m_ffi));
        chk("first_fail_valid", 32'(first_fail_valid), 32'(m_ffv));
        chk("signature", signature, m_sig);
    endtask

    task automatic tick();
        prepare_dut();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
        start = 1'b0;
    endtask

    // One check run: total vectors, nstim stimuli offered (extras must be dropped).
    task automatic run(input int total, input int nstim, input int mask_mode,
                       input int gap_pct, input int fix_exp);
        int sent;
        sent       = 0;
        start      = 1'b1;
        vec_total  = CW'(total);
        stim_valid = 1'b0;
        tick();
        for (int i = 0; i < 600; i++) begin
            if (done) break;
            stim_valid = (sent < nstim) && ($urandom_range(99) >= gap_pct);
            exp_data   = (fix_exp >= 0) ? W'(fix_exp) : W'($urandom);
            exp_mask   = (mask_mode >= 0) ? W'(mask_mode) : W'($urandom);
            if (stim_valid) sent++;
            tick();
        end
        chk("run_completes", 32'(done), 32'd1);
        stim_valid = 1'b0;
        // A few trailing stimuli after completion must change nothing.
        for (int i = 0; i < 3; i++) begin
            stim_valid = (sent < nstim);
            if (stim_valid) sent++;
            tick();
        end
        stim_valid = 1'b0;
    endtask

    task automatic clear_bad();
        for (int i = 0; i < 64; i++) bad_idx[i] = 0;
    endtask

    initial begin
        model_clear();
        clear_bad();
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err_count), 32'd0);
        chk("reset_sig", signature, 32'd0);
        #11;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        tick();

        // Four clean vectors, full mask.
        run(4, 4, 8'hFF, 0, -1);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_err", 32'(err_count), 32'd0);
        chk("t1_ffv", 32'(first_fail_valid), 32'd0);

        // Vectors 1 and 3 off by one bit, with gaps.
        bad_idx[1] = 1; bad_idx[3] = 1; bad_bit = 0;
        run(5, 5, 8'hFF, 30, -1);
        chk("t2_err", 32'(err_count), 32'd2);
        chk("t2_ffi", 32'(first_fail_idx), 32'd1);
        chk("t2_ffv", 32'(first_fail_valid), 32'd1);
        chk("t2_pass", 32'(pass), 32'd0);

        // Every vector differs only in bit 7, which is masked off.
        for (int i = 0; i < 64; i++) bad_idx[i] = 1;
        bad_bit = 7;
        run(4, 6, 8'h0F, 20, -1);
        chk("t3_err", 32'(err_count), 32'd0);
        chk("t3_pass", 32'(pass), 32'd1);
        clear_bad();

        // Empty run: done and pass right after the start pulse; stimuli ignored.
        start = 1'b1; vec_total = '0;
        tick();
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_pass", 32'(pass), 32'd1);
        for (int i = 0; i < 4; i++) begin
            stim_valid = 1'b1; exp_data = W'($urandom); exp_mask = 8'hFF;
            tick();
        end
        stim_valid = 1'b0;
        chk("t4_err", 32'(err_count), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);

        // Reset mid-run after two of six vectors have been checked.
        bad_idx[0] = 1; bad_bit = 2;
        start = 1'b1; vec_total = 16'd6;
        tick();
        for (int i = 0; i < 20 && m_checked < 2; i++) begin
            stim_valid = 1'b1; exp_data = W'($urandom); exp_mask = 8'hFF;
            tick();
        end
        stim_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_err", 32'(err_count), 32'd0);
        chk("t5_ffv", 32'(first_fail_valid), 32'd0);
        check_all();
        @(negedge clk);
        rst = 1'b1;
        tick();
        clear_bad();
        run(3, 3, 8'hFF, 0, -1);
        chk("t5_pass", 32'(pass), 32'd1);
        chk("t5_err2", 32'(err_count), 32'd0);

`ifdef RESP_MISR_EN
        // Single compare of 0x00 under full mask.
        run(1, 1, 8'hFF, 0, 0);
        chk("misr_one", signature, 32'hFB3EE249);
`endif

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 64; i++) bad_idx[i] = ($urandom_range(3) == 0);
            bad_bit = $urandom_range(W - 1);
            begin
                int tot;
                tot = $urandom_range(12, 1);
                run(tot, tot + $urandom_range(3), ($urandom_range(1) == 0) ? -1 : 8'hFF,
                    $urandom_range(50), -1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/response_checker.md
Name: response_checker

Overview:
- Synthesizable response checker: the receiving end of the stimulus/clock/reset generation our generated testbenches perform.
- Accepts one expected-result vector per applied stimulus, aligns it to the DUT output through a fixed-latency delay line, and compares under a mask.
- Reports error count, first failing vector index, pass/done status.
- Used in self-checking benches and on-chip BIST wrappers around small DUTs (gates, adders, counters).

Parameters:
- WIDTH, 8, DUT output / expected-vector width (1..32).
- CNT_W, 16, width of vector counters and error counter.
- LATENCY, 2, cycles from stimulus application to valid DUT output (0..15).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begins a check run
- vec_total  input  CNT_W  number of vectors in the run; sampled on start
- stim_valid  input  1  a stimulus is applied to the DUT this cycle
- exp_data  input  WIDTH  expected DUT output for this stimulus
- exp_mask  input  WIDTH  1 = compare bit, 0 = don't-care
- dut_out  input  WIDTH  DUT output
- busy  output  1  run in progress
- done  output  1  run complete; held until next start
- pass  output  1  valid when done; 1 iff err_count == 0
- err_count  output  CNT_W  mismatching vectors, saturating
- first_fail_idx  output  CNT_W  index (0-based) of first mismatching vector
- first_fail_valid  output  1  first_fail_idx is meaningful
- signature  output  32  MISR signature (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy=0, done=0, pass=0, err_count=0, first_fail_idx=0, first_fail_valid=0, signature=0; delay line valid bits cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start: clear counters and flags, latch vec_total, go to RUN.
  - If latched vec_total==0: go directly to DONE next cycle, pass=1.
  - RUN: start ignored.
  - RUN -> DONE when checked count reaches vec_total; that compare's result is included.
  - DONE: done=1, pass registered; busy=0.
- Delay line: LATENCY stages of {valid, exp_data, exp_mask}. In RUN, a stim_valid entry emerges after exactly LATENCY cycles; LATENCY=0 compares in the same cycle.
- stim_valid is ignored outside RUN and once issued count == vec_total. Extra stimuli are dropped.
- Compare: mismatch = |((dut_out ^ exp) & mask). Each emerging valid entry increments checked count.
- On mismatch:
  - err_count += 1, saturating at all-ones.
  - On the first mismatch, capture first_fail_idx = checked index and set first_fail_valid=1.
- Gaps in stim_valid are allowed; alignment is per-entry, not per-cycle.
- Outputs are registered; err_count updates the cycle after the compare cycle.
- Reset mid-run: run is abandoned, all state cleared, IDLE.

Optional Feature:
- RESP_MISR_EN defined: 32-bit MISR, seed 0xFFFFFFFF loaded on start.
  - On each compared entry: sig = {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ zero-extended (dut_out & exp_mask).
  - signature holds the value until next start.
- Undefined: signature tied to 0; no MISR logic.

Decomposition:
- Shared package resp_chk_pkg: FSM state enum (IDLE/RUN/DONE), MISR_POLY and MISR_SEED constants.
- One sub-module, resp_delay_line: parameterized WIDTH/LATENCY shift register carrying valid+data+mask, with async active-low clear of valid bits.

Test Plan:
- LATENCY=2, vec_total=4, all four vectors match, mask all-ones -> done after last compare; pass=1, err_count=0, first_fail_valid=0.
- LATENCY=2, vec_total=5, vectors 1 and 3 mismatch by one bit -> err_count=2, first_fail_idx=1, pass=0.
- Mismatch only in masked bits (exp_mask=8'h0F, diff in bit 7) -> err_count=0, pass=1.
- vec_total=0 with start -> done=1, pass=1 on the next cycle; stim_valid ignored.
- Reset asserted mid-run after 2 of 6 vectors -> all outputs 0 immediately; a new start with vec_total=3 runs clean.
- RESP_MISR_EN, WIDTH=8, one compare of dut_out=8'h00 with mask 8'hFF -> signature = 32'hFFFFFFFE ^ 32'h04C11DB7 = 32'hFB3EE249.
